// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - write-back arbiter bus bundle (pipeline, long-latency unit, regfile, scoreboard)
interface wb_arbiter_if;
  logic        pipe_wr_en;
  logic [4:0]  pipe_dest_addr;
  logic [31:0] pipe_wr_data;
  logic        issue_en;
  logic [4:0]  issue_dest;
  logic        lu_valid;
  logic [4:0]  lu_dest;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_wr_en;
  logic [4:0]  rf_dest_addr;
  logic [31:0] rf_wr_data;
  logic [31:0] pending;

  // Upstream side: pipeline, decode and long-latency unit drive; observe regfile write and scoreboard
  modport master (
    output pipe_wr_en, pipe_dest_addr, pipe_wr_data,
    output issue_en, issue_dest,
    output lu_valid, lu_dest, lu_data,
    input  lu_ready,
    input  rf_wr_en, rf_dest_addr, rf_wr_data,
    input  pending
  );

  // Arbiter side
  modport slave (
    input  pipe_wr_en, pipe_dest_addr, pipe_wr_data,
    input  issue_en, issue_dest,
    input  lu_valid, lu_dest, lu_data,
    output lu_ready,
    output rf_wr_en, rf_dest_addr, rf_wr_data,
    output pending
  );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges pipeline and long-latency results onto one registered regfile write port
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         nrst,
  wb_arbiter_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [4:0]   mem_dest [DEPTH];
  logic [31:0]  mem_data [DEPTH];

  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic [4:0]   head_dest;
  logic [31:0]  head_data;

  logic         rf_wr_en_q;
  logic [4:0]   rf_dest_q;
  logic [31:0]  rf_data_q;
  logic [31:0]  pending_q;
  logic [31:0]  pending_d;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign push      = bus.lu_valid && !full;
  // The pipeline is never stalled, so the FIFO head only drains on idle pipeline cycles
  assign pop       = !bus.pipe_wr_en && !empty;
  assign head_dest = mem_dest[rd_ptr[AW-1:0]];
  assign head_data = mem_data[rd_ptr[AW-1:0]];

  assign bus.lu_ready     = !full;
  assign bus.rf_wr_en     = rf_wr_en_q;
  assign bus.rf_dest_addr = rf_dest_q;
  assign bus.rf_wr_data   = rf_data_q;
  assign bus.pending      = pending_q;

  // FIFO storage; entries are only meaningful between the pointers, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dest[wr_ptr[AW-1:0]] <= bus.lu_dest;
      mem_data[wr_ptr[AW-1:0]] <= bus.lu_data;
    end
  end

  // FIFO pointer advance on push and pop
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Registered regfile write: pipeline first, then FIFO head; x0 writes are suppressed
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rf_wr_en_q <= 1'b0;
      rf_dest_q  <= '0;
      rf_data_q  <= '0;
    end else if (bus.pipe_wr_en) begin
      rf_wr_en_q <= (bus.pipe_dest_addr != 5'd0);
      rf_dest_q  <= bus.pipe_dest_addr;
      rf_data_q  <= bus.pipe_wr_data;
    end else if (pop) begin
      rf_wr_en_q <= (head_dest != 5'd0);
      rf_dest_q  <= head_dest;
      rf_data_q  <= head_data;
    end else begin
      rf_wr_en_q <= 1'b0;
    end
  end

  // Scoreboard next state: clear on pop, then set on issue so a same-index set wins
  always_comb begin
    pending_d = pending_q;
    if (pop) pending_d[head_dest] = 1'b0;
    if (bus.issue_en && (bus.issue_dest != 5'd0)) pending_d[bus.issue_dest] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) pending_q <= '0;
    else       pending_q <= pending_d;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized self-checking bench for wb_arbiter against a queue-based model
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic nrst;
  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: result queue, last regfile write, scoreboard bit vector
  ent_t        q[$];
  logic        m_en;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  logic [31:0] m_pend;
  logic        accepted;

  task automatic model_reset();
    q.delete();
    m_en = 1'b0; m_dest = '0; m_data = '0; m_pend = '0;
  endtask

  task automatic cycle(input logic pw, input logic [4:0] pd, input logic [31:0] pdat,
                       input logic ie, input logic [4:0] id,
                       input logic lv, input logic [4:0] ld, input logic [31:0] ldat);
    ent_t e;
    @(negedge clk);
    bus.pipe_wr_en = pw; bus.pipe_dest_addr = pd; bus.pipe_wr_data = pdat;
    bus.issue_en = ie;   bus.issue_dest = id;
    bus.lu_valid = lv;   bus.lu_dest = ld;       bus.lu_data = ldat;
    accepted = lv && (q.size() < DEPTH);
    if (pw) begin
      m_en = (pd != 5'd0); m_dest = pd; m_data = pdat;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_en = (e.dest != 5'd0); m_dest = e.dest; m_data = e.data;
      m_pend[e.dest] = 1'b0;
    end else begin
      m_en = 1'b0;
    end
    if (ie && id != 5'd0) m_pend[id] = 1'b1;
    m_pend[0] = 1'b0;
    if (accepted) q.push_back({ld, ldat});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", bus.rf_wr_en); end
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL reset_lu_ready got=%b exp=1", bus.lu_ready); end
    checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL reset_pending got=%h exp=0", bus.pending); end
    // Leave one entry in the FIFO and one pending bit, then reset asynchronously mid-cycle
    cycle(1, 5'd4, 32'h1111_2222, 1, 5'd9, 1, 5'd9, 32'h9999_9999);
    @(negedge clk);
    bus.pipe_wr_en = 0; bus.issue_en = 0; bus.lu_valid = 0;
    #2 nrst = 1'b0;
    #1;
    checks++; if (bus.rf_wr_en !== 1'b0 || bus.rf_dest_addr !== 5'd0 || bus.rf_wr_data !== 32'h0)
      begin errors++; $display("FAIL async_reset_rf got=%b/%0d/%h exp=0/0/0", bus.rf_wr_en, bus.rf_dest_addr, bus.rf_wr_data); end
    checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL async_reset_pending got=%h exp=0", bus.pending); end
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL async_reset_lu_ready got=%b exp=1", bus.lu_ready); end
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
    idle();
    checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_discard got=%b exp=0", bus.rf_wr_en); end
  endtask

  task automatic test_pipe();
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_dest_addr !== 5'd5 || bus.rf_wr_data !== 32'hDEADBEEF)
      begin errors++; $display("FAIL pipe_write got=%b/%0d/%h exp=1/5/deadbeef", bus.rf_wr_en, bus.rf_dest_addr, bus.rf_wr_data); end
    idle();
    checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL pipe_one_cycle got=%b exp=0", bus.rf_wr_en); end
    checks++; if (bus.rf_dest_addr !== 5'd5 || bus.rf_wr_data !== 32'hDEADBEEF)
      begin errors++; $display("FAIL pipe_hold got=%0d/%h exp=5/deadbeef", bus.rf_dest_addr, bus.rf_wr_data); end
  endtask

  task automatic test_x0();
    cycle(1, 5'd0, 32'hADE1B055, 0, 0, 0, 0, 0);
    checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL x0_pipe got=%b exp=0", bus.rf_wr_en); end
    cycle(0, 0, 0, 1, 5'd0, 0, 0, 0);
    checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL x0_issue got=%h exp=0", bus.pending); end
    cycle(0, 0, 0, 0, 0, 1, 5'd0, 32'h0BAD_0000);
    idle();
    checks++; if (bus.rf_wr_en !== 1'b0 || bus.lu_ready !== 1'b1)
      begin errors++; $display("FAIL x0_fifo got=%b/%b exp=0/1", bus.rf_wr_en, bus.lu_ready); end
  endtask

  task automatic test_long();
    cycle(0, 0, 0, 1, 5'd10, 0, 0, 0);
    checks++; if (bus.pending[10] !== 1'b1) begin errors++; $display("FAIL long_issue got=%b exp=1", bus.pending[10]); end
    cycle(0, 0, 0, 0, 0, 1, 5'd10, 32'h12345678);
    checks++; if (bus.rf_wr_en !== 1'b0 || bus.pending[10] !== 1'b1)
      begin errors++; $display("FAIL long_after_push got=%b/%b exp=0/1", bus.rf_wr_en, bus.pending[10]); end
    idle();
    checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_dest_addr !== 5'd10 || bus.rf_wr_data !== 32'h12345678)
      begin errors++; $display("FAIL long_write got=%b/%0d/%h exp=1/10/12345678", bus.rf_wr_en, bus.rf_dest_addr, bus.rf_wr_data); end
    checks++; if (bus.pending[10] !== 1'b0) begin errors++; $display("FAIL long_clear got=%b exp=0", bus.pending[10]); end
  endtask

  task automatic test_backpressure();
    logic [4:0] next;
    logic       exp_ready [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    next = 5'd1;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 5'(20 + i), 32'hC0DE_0000 + 32'(i), 0, 0, 1, next, 32'hB000_0000 + 32'(next));
      if (accepted) next = next + 5'd1;
      checks++; if (bus.lu_ready !== exp_ready[i])
        begin errors++; $display("FAIL bp_ready_%0d got=%b exp=%b", i, bus.lu_ready, exp_ready[i]); end
    end
    checks++; if (next !== 5'd3) begin errors++; $display("FAIL bp_pushes got=%0d exp=2", next - 5'd1); end
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 0, 0, 0, 0, next <= 5'd3, next, 32'hB000_0000 + 32'(next));
      if (accepted) next = next + 5'd1;
      checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_dest_addr !== 5'(i) || bus.rf_wr_data !== 32'hB000_0000 + 32'(i))
        begin errors++; $display("FAIL bp_drain_%0d got=%b/%0d/%h exp=1/%0d", i, bus.rf_wr_en, bus.rf_dest_addr, bus.rf_wr_data, i); end
    end
  endtask

  task automatic test_collision();
    cycle(0, 0, 0, 1, 5'd7, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 5'd7, 32'h7777_0007);
    cycle(0, 0, 0, 1, 5'd7, 0, 0, 0);
    checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_dest_addr !== 5'd7)
      begin errors++; $display("FAIL coll_write got=%b/%0d exp=1/7", bus.rf_wr_en, bus.rf_dest_addr); end
    checks++; if (bus.pending[7] !== 1'b1) begin errors++; $display("FAIL coll_pending got=%b exp=1", bus.pending[7]); end
  endtask

  task automatic test_wrap();
    logic [4:0] next;
    ent_t       seen[$];
    int         guard;
    next = 5'd1;
    guard = 0;
    while ((next <= 5'd10 || q.size() > 0) && guard < 200) begin
      cycle($urandom_range(0, 2) == 0, 5'($urandom_range(11, 31)), {4'h5, 28'($urandom)},
            0, 0, next <= 5'd10, next, 32'hA000_0000 + 32'(next));
      if (accepted) next = next + 5'd1;
      guard++;
      if (bus.rf_wr_en === 1'b1 && bus.rf_wr_data[31:28] === 4'hA) seen.push_back({bus.rf_dest_addr, bus.rf_wr_data});
      checks++; if (bus.rf_wr_en !== m_en || bus.rf_dest_addr !== m_dest || bus.rf_wr_data !== m_data)
        begin errors++; $display("FAIL wrap_rf got=%b/%0d/%h exp=%b/%0d/%h", bus.rf_wr_en, bus.rf_dest_addr, bus.rf_wr_data, m_en, m_dest, m_data); end
    end
    checks++; if (guard >= 200) begin errors++; $display("FAIL wrap_timeout got=%0d cycles exp<200", guard); end
    checks++; if (seen.size() != 10) begin errors++; $display("FAIL wrap_count got=%0d exp=10", seen.size()); end
    for (int i = 0; i < seen.size() && i < 10; i++) begin
      checks++; if (seen[i].dest !== 5'(i + 1) || seen[i].data !== 32'hA000_0000 + 32'(i + 1))
        begin errors++; $display("FAIL wrap_order_%0d got=%0d/%h exp=%0d", i, seen[i].dest, seen[i].data, i + 1); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1), 5'($urandom), $urandom, $urandom_range(0, 3) == 0, 5'($urandom),
            $urandom_range(0, 1), 5'($urandom), $urandom);
      checks++; if (bus.rf_wr_en !== m_en || bus.rf_dest_addr !== m_dest || bus.rf_wr_data !== m_data)
        begin errors++; $display("FAIL rand_rf_%0d got=%b/%0d/%h exp=%b/%0d/%h", i, bus.rf_wr_en, bus.rf_dest_addr, bus.rf_wr_data, m_en, m_dest, m_data); end
      checks++; if (bus.pending !== m_pend)
        begin errors++; $display("FAIL rand_pending_%0d got=%h exp=%h", i, bus.pending, m_pend); end
      checks++; if (bus.lu_ready !== (q.size() < DEPTH))
        begin errors++; $display("FAIL rand_ready_%0d got=%b exp=%b", i, bus.lu_ready, q.size() < DEPTH); end
    end
  endtask

  initial begin
    nrst = 1'b0;
    bus.pipe_wr_en = 0; bus.pipe_dest_addr = 0; bus.pipe_wr_data = 0;
    bus.issue_en = 0;   bus.issue_dest = 0;
    bus.lu_valid = 0;   bus.lu_dest = 0;        bus.lu_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    test_reset();
    test_pipe();
    test_x0();
    test_long();
    test_backpressure();
    test_collision();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
